frame_stream_arbiter: RTL
=========================

FRAME_STREAM_ARBITER -- requirements
Module: frame_stream_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, tdata width of all stream ports.
REQ-002 SHALL have parameter IMG_HEIGHT, default 480, lines (tlast beats) per frame.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port resetn  input  1  reset resetn, synchronous, active-low; clock clk.
REQ-005 SHALL have ports s0_axis_tdata/tvalid/tlast/tuser  input  DATA_WIDTH/1/1/1  requester 0 stream; s0_axis_tready  output  1.
REQ-006 SHALL have ports s1_axis_tdata/tvalid/tlast/tuser  input  DATA_WIDTH/1/1/1  requester 1 stream; s1_axis_tready  output  1.
REQ-007 SHALL have ports m_axis_tdata/tvalid/tlast/tuser  output  DATA_WIDTH/1/1/1  to shared padding/conv pipeline; m_axis_tready  input  1.
REQ-008 SHALL have port grant_id  output  1  source currently granted (valid while busy=1).
REQ-009 SHALL have port busy  output  1  high in GRANT state.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse after a frame's last beat transfers.
REQ-011 SHALL have port sof_err  output  1  one-cycle pulse per discarded non-SOF beat in IDLE.

Function
REQ-012 SHALL implement FSM states IDLE and GRANT; arbitration only in IDLE, switching only on frame boundaries.
REQ-013 In IDLE, a request SHALL be tvalid=1 and tuser=1 on a source; m_axis_tvalid=0; requesting sources' tready=0.
REQ-014 In IDLE, a source with tvalid=1, tuser=0 SHALL get tready=1 (beat discarded) and assert sof_err next cycle.
REQ-015 On request(s) in IDLE, FSM SHALL register grant_id and enter GRANT next cycle (one-cycle grant latency).
REQ-016 Both requesting simultaneously: grant SHALL go to the source not last served (round-robin pointer last_id).
REQ-017 In GRANT, datapath SHALL be combinational pass-through, zero latency: m_axis_* = granted s*_axis_*, granted tready = m_axis_tready.
REQ-018 In GRANT, non-granted tready SHALL be 0; its beats held untouched.
REQ-019 In GRANT, line counter (width clog2(IMG_HEIGHT)) SHALL increment on each m_axis tvalid&tready&tlast.
REQ-020 On tlast handshake with line counter = IMG_HEIGHT-1: counter SHALL clear, last_id <= grant_id, FSM -> IDLE, frame_done pulse next cycle.
REQ-021 tuser=1 on granted source mid-frame SHALL pass through unmodified and not affect counting or state.
REQ-022 m_axis_tvalid stall (m_axis_tready=0) SHALL hold state and counter; tvalid SHALL not depend on tready.

Reset
REQ-023 resetn=0 SHALL force IDLE, line counter 0, last_id=1 (source 0 wins first tie), grant_id=0.
REQ-024 During and one cycle after reset: all tready=0, m_axis_tvalid=0, busy=0, frame_done=0, sof_err=0.
REQ-025 Reset mid-frame SHALL abandon the frame without any frame_done pulse.

Configuration
REQ-026 Macro FRAME_ARB_STATS_EN defined: SHALL add outputs frames_s0, frames_s1 (16 bits each, reset 0, +1 per frame_done for that source, wrap 65535->0).
REQ-027 Macro FRAME_ARB_STATS_EN undefined: ports and counters SHALL be absent; all other behaviour identical.

Verification (IMG_HEIGHT=4, 3 beats/line)
REQ-028 s0 SOF frame 12 beats, m_axis_tready=1 -> output identical data, grant_id=0, one frame_done after beat 12, back to IDLE.
REQ-029 s0 and s1 raise SOF same cycle after reset -> s0 served first, s1 tready=0 until s0 done, then s1 frame (grant_id=1).
REQ-030 Next simultaneous request after s1 served last -> s0 granted; repeat with s0 last -> s1 granted.
REQ-031 s1 sends 2 beats tuser=0 in IDLE -> both consumed, two sof_err pulses, no m_axis_tvalid.
REQ-032 m_axis_tready toggles 1/0 every cycle mid-frame -> no lost/duplicated beats, frame_done only after 4th tlast.
REQ-033 resetn=0 after line 2 of s0 frame -> IDLE, no frame_done; new s1 SOF then granted normally; with FRAME_ARB_STATS_EN frames_s0 unchanged.

Source files
------------

// File: rtl/frame_stream_arbiter.sv
// Two-source frame-granular AXI-Stream arbiter with round-robin tie-break.
// Optional per-source frame counters when FRAME_ARB_STATS_EN is defined.
module frame_stream_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                  s0_axis_tvalid,
    input  logic                  s0_axis_tlast,
    input  logic                  s0_axis_tuser,
    output logic                  s0_axis_tready,
    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                  s1_axis_tvalid,
    input  logic                  s1_axis_tlast,
    input  logic                  s1_axis_tuser,
    output logic                  s1_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic                  m_axis_tready,
    output logic                  grant_id,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  sof_err
`ifdef FRAME_ARB_STATS_EN
    ,
    output logic [15:0]           frames_s0,
    output logic [15:0]           frames_s1
`endif
);

    localparam int CW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] LAST_LINE = CW'(IMG_HEIGHT - 1);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          gid;
    logic          last_id;
    logic          live;
    logic          en;
    logic [CW-1:0] line_cnt;
    logic          done_q;
    logic          err_q;
    logic          req0;
    logic          req1;
    logic          pick;
    logic          grab;
    logic          junk;
    logic          beat;
    logic          frame_end;

    // live stays low for the reset cycles and the first cycle after them
    assign en        = live & resetn;
    assign req0      = s0_axis_tvalid & s0_axis_tuser;
    assign req1      = s1_axis_tvalid & s1_axis_tuser;
    assign pick      = (req0 & req1) ? ~last_id : req1;
    assign grab      = en & (state == IDLE) & (req0 | req1);
    assign junk      = en & (state == IDLE) &
                       ((s0_axis_tvalid & ~s0_axis_tuser) |
                        (s1_axis_tvalid & ~s1_axis_tuser));
    assign beat      = m_axis_tvalid & m_axis_tready & m_axis_tlast;
    assign frame_end = beat & (line_cnt == LAST_LINE);

    assign grant_id   = gid;
    assign busy       = (state == GRANT) & resetn;
    assign frame_done = done_q & resetn;
    assign sof_err    = err_q & resetn;

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next state: grant on any SOF request, release on the frame's last line
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grab)      state_nxt = GRANT;
            GRANT:   if (frame_end) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Outputs: discard non-SOF beats in IDLE, pass the granted source through in GRANT
    always_comb begin
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        m_axis_tvalid  = 1'b0;
        m_axis_tdata   = gid ? s1_axis_tdata : s0_axis_tdata;
        m_axis_tlast   = gid ? s1_axis_tlast : s0_axis_tlast;
        m_axis_tuser   = gid ? s1_axis_tuser : s0_axis_tuser;
        case (state)
            IDLE: begin
                s0_axis_tready = en & s0_axis_tvalid & ~s0_axis_tuser;
                s1_axis_tready = en & s1_axis_tvalid & ~s1_axis_tuser;
            end
            GRANT: begin
                if (gid) begin
                    m_axis_tvalid  = en & s1_axis_tvalid;
                    s1_axis_tready = en & m_axis_tready;
                end else begin
                    m_axis_tvalid  = en & s0_axis_tvalid;
                    s0_axis_tready = en & m_axis_tready;
                end
            end
            default: ;
        endcase
    end

    // Grant, round-robin pointer, line counter and status pulses
    always_ff @(posedge clk) begin
        if (!resetn) begin
            live     <= 1'b0;
            gid      <= 1'b0;
            last_id  <= 1'b1;
            line_cnt <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            live   <= 1'b1;
            done_q <= frame_end;
            err_q  <= junk;
            if (grab) gid <= pick;
            if (beat) begin
                if (frame_end) begin
                    line_cnt <= '0;
                    last_id  <= gid;
                end else begin
                    line_cnt <= line_cnt + 1'b1;
                end
            end
        end
    end

`ifdef FRAME_ARB_STATS_EN
    // Per-source completed-frame counters, wrapping at 16 bits
    always_ff @(posedge clk) begin
        if (!resetn) begin
            frames_s0 <= '0;
            frames_s1 <= '0;
        end else if (frame_end) begin
            if (gid) frames_s1 <= frames_s1 + 16'd1;
            else     frames_s0 <= frames_s0 + 16'd1;
        end
    end
`endif

endmodule
